relay_nibble_scheduler: RTL and testbench
=========================================

Name: relay_nibble_scheduler

Overview:
- Sequences the nibble stream that drives the relay-mode framer during FAKE_READER and FAKE_TAG operation.
- Accepts bytes from the ARM/SSP side through a valid/ready handshake and buffers them in a small FIFO.
- Wraps each frame in the mode-specific start nibble and trailing zero nibbles.
- Emits one nibble plus a one-cycle data_in_available-style strobe every NIBBLE_PERIOD clocks, which matches the framer's 16-clock bit shift (4 bits per nibble).

Parameters:
- NIBBLE_PERIOD, 64, clocks between consecutive nibble strobes (4 bits x 16 clk).
- FIFO_DEPTH, 16, byte entries in the input FIFO (power of two).
- GUARD_NIBBLES, 2, minimum silent nibble periods between the end of one frame and the next start.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- hi_simulate_mod_type  input  3  mode select; 3'b101 = FAKE_READER, 3'b110 = FAKE_TAG
- byte_in  input  8  payload byte
- byte_in_last  input  1  qualifies byte_in as the final byte of a frame
- byte_in_valid  input  1  producer has a byte
- byte_in_ready  output  1  FIFO can accept; a transfer occurs when valid & ready
- nibble_out  output  4  nibble presented to the framer
- nibble_out_available  output  1  one-cycle strobe qualifying nibble_out
- busy  output  1  high in any state other than IDLE
- underrun  output  1  sticky; a frame ran dry before its last byte

Behaviour:
- Reset, applied synchronously on a clk edge with reset=1:
  - all outputs go to 0; byte_in_ready then rises on the following cycle.
  - FIFO is emptied, state returns to IDLE, pace counter is cleared.
- Mode gating:
  - When hi_simulate_mod_type is neither 101 nor 110, the block is held in IDLE and the FIFO is flushed every cycle.
  - In that condition byte_in_ready=1 and accepted bytes are discarded.
  - A mode change in any non-IDLE state aborts to IDLE on the next cycle: FIFO is flushed, no further strobes are issued, and underrun is unchanged.
- FIFO:
  - Entries are 9 bits wide: {last, byte}.
  - byte_in_ready = !full, based on the registered count.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Pace counter:
  - Counts 0..NIBBLE_PERIOD-1 while not in IDLE and wraps to 0.
  - A nibble strobe occurs only on count==0.
  - The counter is cleared on entry to START.
- States:
  - IDLE: wait for FIFO non-empty and mode valid, then go to START. The pace counter is held at 0, so the first strobe occurs on the cycle after entering START.
  - START: strobe the start nibble, 4'hC in FAKE_READER or 4'hF in FAKE_TAG. Go to DATA_HI.
  - DATA_HI: at the strobe slot, if the FIFO is non-empty, pop the head, strobe byte[7:4], latch byte[3:0] and the last flag, then go to DATA_LO. If the FIFO is empty, set underrun and go to END; no strobe is issued.
  - DATA_LO: strobe the latched low nibble. If the latched last flag is set go to END, else go to DATA_HI.
  - END: strobe 4'h0 on successive slots, 4 nibbles in FAKE_READER and 2 in FAKE_TAG. This produces the framer's 16'h0000 and 8'h00 end patterns. Then go to GUARD.
  - GUARD: GUARD_NIBBLES slots with no strobe, then go to IDLE.
- nibble_out holds its last value between strobes and is 0 after reset.
- nibble_out_available is high exactly on strobe cycles, never two consecutive cycles.
- underrun clears only on reset.
- A byte pushed while a frame is in progress belongs to that frame unless the previous popped byte carried last.

Test Plan:
- FAKE_READER: push 0x26 with last=1. Strobes must be C,2,6,0,0,0,0, spaced exactly 64 clocks apart, first strobe 2 cycles after the push. busy falls 2 periods after the final strobe.
- FAKE_TAG: push 0x04,0x00 with last on the 2nd byte. Strobes must be F,0,4,0,0,0,0 (2 data bytes followed by 2 end zeros), 7 strobes total.
- FIFO full: with mode=101, push 16 bytes with no pop before the first DATA_HI slot. byte_in_ready must drop after the 16th push, then return 1 one cycle after the first pop.
- Underrun: push 0x93 with last=0 and nothing else. Strobes must be C,9,3,0,0,0,0, and underrun=1 after the slot following the 3.
- Mode abort: switch mode 101 to 000 mid-DATA_LO. No strobes after that cycle, FIFO empty, busy=0 the next cycle, byte_in_ready=1.
- Reset mid-frame: assert reset for 1 cycle during END. All outputs are 0 the next cycle and the next pushed frame starts cleanly with a C strobe.

Source files
------------

// File: rtl/relay_nibble_scheduler.sv
// Buffers framer bytes and replays them as start/data/end nibbles, one strobe every NIBBLE_PERIOD clocks.
// First strobe two cycles after the first push; byte_in_ready drops while the FIFO is full.
module relay_nibble_scheduler #(
   parameter int NIBBLE_PERIOD = 64,
   parameter int FIFO_DEPTH    = 16,
   parameter int GUARD_NIBBLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] hi_simulate_mod_type,
   input  logic [7:0] byte_in,
   input  logic       byte_in_last,
   input  logic       byte_in_valid,
   output logic       byte_in_ready,
   output logic [3:0] nibble_out,
   output logic       nibble_out_available,
   output logic       busy,
   output logic       underrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = $clog2(NIBBLE_PERIOD);
   localparam logic [2:0] MODE_READER = 3'b101;
   localparam logic [2:0] MODE_TAG    = 3'b110;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA_HI, S_DATA_LO, S_END, S_GUARD} state_t;

   state_t        state;
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [PW-1:0] pace;
   logic [3:0]    slot_cnt;
   logic [3:0]    lo_nib;
   logic          lo_last;
   logic          rdy_en;
   logic [2:0]    frame_mode;

   logic       mode_ok, abort, flush, full, empty, slot, push, pop;
   logic [8:0] head;
   logic [3:0] end_last, start_nib;

   assign mode_ok   = (hi_simulate_mod_type == MODE_READER) || (hi_simulate_mod_type == MODE_TAG);
   // A frame is bound to the mode it started in; any change tears it down.
   assign abort     = (state != S_IDLE) && (hi_simulate_mod_type != frame_mode);
   assign flush     = !mode_ok || abort;
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign slot      = (pace == '0);
   assign push      = byte_in_valid && byte_in_ready && !flush;
   assign pop       = (state == S_DATA_HI) && slot && !empty && !flush;
   assign head      = mem[rd_ptr];
   assign end_last  = (frame_mode == MODE_TAG) ? 4'd1 : 4'd3;
   assign start_nib = (frame_mode == MODE_TAG) ? 4'hF : 4'hC;

   assign byte_in_ready = rdy_en && !full;
   assign busy          = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {byte_in_last, byte_in};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= S_IDLE;
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         count                <= '0;
         pace                 <= '0;
         slot_cnt             <= '0;
         lo_nib               <= '0;
         lo_last              <= 1'b0;
         rdy_en               <= 1'b0;
         frame_mode           <= '0;
         nibble_out           <= '0;
         nibble_out_available <= 1'b0;
         underrun             <= 1'b0;
      end else begin
         rdy_en               <= 1'b1;
         nibble_out_available <= 1'b0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (state == S_IDLE)                          pace <= '0;
         else if (pace == PW'(NIBBLE_PERIOD - 1))      pace <= '0;
         else                                          pace <= pace + 1'b1;

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pace   <= '0;
            state  <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (!empty) begin
                     state      <= S_START;
                     frame_mode <= hi_simulate_mod_type;
                  end
               end
               S_START: begin
                  if (slot) begin
                     nibble_out           <= start_nib;
                     nibble_out_available <= 1'b1;
                     state                <= S_DATA_HI;
                  end
               end
               S_DATA_HI: begin
                  if (slot) begin
                     if (!empty) begin
                        nibble_out           <= head[7:4];
                        nibble_out_available <= 1'b1;
                        lo_nib               <= head[3:0];
                        lo_last              <= head[8];
                        state                <= S_DATA_LO;
                     end else begin
                        underrun <= 1'b1;
                        slot_cnt <= '0;
                        state    <= S_END;
                     end
                  end
               end
               S_DATA_LO: begin
                  if (slot) begin
                     nibble_out           <= lo_nib;
                     nibble_out_available <= 1'b1;
                     slot_cnt             <= '0;
                     state                <= lo_last ? S_END : S_DATA_HI;
                  end
               end
               S_END: begin
                  if (slot) begin
                     nibble_out           <= 4'h0;
                     nibble_out_available <= 1'b1;
                     if (slot_cnt == end_last) begin
                        slot_cnt <= '0;
                        state    <= S_GUARD;
                     end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                     end
                  end
               end
               S_GUARD: begin
                  if (slot) begin
                     if (slot_cnt == 4'(GUARD_NIBBLES - 1)) begin
                        pace  <= '0;
                        state <= S_IDLE;
                     end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_relay_nibble_scheduler.sv
// Directed bench for relay_nibble_scheduler with a nibble scoreboard and strobe-spacing checks.
module tb_relay_nibble_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] mode;
   logic [7:0] byte_in;
   logic       byte_in_last;
   logic       byte_in_valid;
   logic       byte_in_ready;
   logic [3:0] nibble_out;
   logic       nibble_out_available;
   logic       busy;
   logic       underrun;

   relay_nibble_scheduler dut (
      .clk                  (clk),
      .reset                (reset),
      .hi_simulate_mod_type (mode),
      .byte_in              (byte_in),
      .byte_in_last         (byte_in_last),
      .byte_in_valid        (byte_in_valid),
      .byte_in_ready        (byte_in_ready),
      .nibble_out           (nibble_out),
      .nibble_out_available (nibble_out_available),
      .busy                 (busy),
      .underrun             (underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] nib;
      int         gap;   // required clocks since previous strobe, 0 = unchecked
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] bq[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_strobe_cyc = 0;
   int strobe_cnt = 0;
   int push_cyc = 0;
   int base = 0;
   int t0 = 0;
   logic prev_avail = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expn(input logic [3:0] n, input int gap);
      exp_t e;
      e.nib = n;
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Frame built from bq: start nibble, hi/lo per byte, end zeros.
   task automatic add_frame(input logic [3:0] st, input int end_n, input bit und);
      expn(st, 0);
      foreach (bq[i]) begin
         expn(bq[i][7:4], 64);
         expn(bq[i][3:0], 64);
      end
      for (int k = 0; k < end_n; k++) expn(4'h0, (k == 0 && und) ? 128 : 64);
      bq.delete();
   endtask

   task automatic push_byte(input logic [7:0] b, input logic l);
      byte_in       = b;
      byte_in_last  = l;
      byte_in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (byte_in_ready) break;
         step();
      end
      chk("push_ready", int'(byte_in_ready), 1);
      step();
      push_cyc      = cyc;
      byte_in_valid = 1'b0;
   endtask

   task automatic chk_first_latency();
      for (int i = 0; i < 10; i++) begin
         if (nibble_out_available) break;
         step();
      end
      chk("first_strobe_latency", cyc - push_cyc, 2);
   endtask

   task automatic wait_strobes(input int target);
      for (int i = 0; i < 3000; i++) begin
         if (strobe_cnt >= target) break;
         step();
      end
      chk("strobe_wait", int'(strobe_cnt >= target), 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         if (!busy && exp_q.size() == 0) break;
         step();
      end
      chk("idle_busy", int'(busy), 0);
      chk("idle_queue", exp_q.size(), 0);
   endtask

   // Strobe monitor: pops the scoreboard and checks spacing.
   always @(posedge clk) begin
      #1;
      if (nibble_out_available === 1'b1) begin
         vectors++;
         assert (!prev_avail) else begin
            miscompares++;
            $error("FAIL back_to_back_strobe: observed 1 expected 0");
         end
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL extra_strobe: observed nibble %0h expected none", nibble_out);
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("nibble", int'(nibble_out), int'(mon_e.nib));
            if (mon_e.gap != 0) chk("strobe_gap", cyc - last_strobe_cyc, mon_e.gap);
         end
         last_strobe_cyc = cyc;
         strobe_cnt++;
      end
      prev_avail = nibble_out_available;
   end

   initial begin
      reset         = 1'b1;
      mode          = 3'b000;
      byte_in       = 8'h00;
      byte_in_last  = 1'b0;
      byte_in_valid = 1'b0;
      step();
      step();
      chk("rst_nibble", int'(nibble_out), 0);
      chk("rst_avail", int'(nibble_out_available), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_ready", int'(byte_in_ready), 0);
      reset = 1'b0;
      step();
      chk("ready_after_rst", int'(byte_in_ready), 1);

      // Invalid mode: bytes are accepted and discarded.
      byte_in = 8'hEE; byte_in_last = 1'b1; byte_in_valid = 1'b1;
      repeat (3) step();
      chk("flush_ready", int'(byte_in_ready), 1);
      byte_in_valid = 1'b0;
      mode = 3'b101;
      repeat (5) step();
      chk("flush_discard_busy", int'(busy), 0);

      // FAKE_READER single byte
      bq.push_back(8'h26);
      add_frame(4'hC, 4, 1'b0);
      push_byte(8'h26, 1'b1);
      chk_first_latency();
      for (int i = 0; i < 1000; i++) begin
         if (!busy) break;
         step();
      end
      chk("busy_fall", cyc - last_strobe_cyc, 128);
      wait_idle();

      // FAKE_TAG two bytes
      mode = 3'b110;
      repeat (3) step();
      base = strobe_cnt;
      bq.push_back(8'h04);
      bq.push_back(8'h00);
      add_frame(4'hF, 2, 1'b0);
      push_byte(8'h04, 1'b0);
      push_byte(8'h00, 1'b1);
      wait_idle();
      chk("tag_strobes", strobe_cnt - base, 7);

      // FIFO full
      mode = 3'b101;
      repeat (3) step();
      for (int i = 0; i < 16; i++) bq.push_back(8'(i));
      add_frame(4'hC, 4, 1'b0);
      byte_in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         byte_in      = 8'(i);
         byte_in_last = (i == 15);
         step();
      end
      chk("full_ready", int'(byte_in_ready), 0);
      byte_in_valid = 1'b0;
      t0 = last_strobe_cyc;
      for (int i = 0; i < 200; i++) begin
         if (byte_in_ready) break;
         step();
      end
      chk("ready_after_pop", cyc - t0, 64);
      wait_idle();

      // Underrun
      chk("underrun_before", int'(underrun), 0);
      base = strobe_cnt;
      bq.push_back(8'h93);
      add_frame(4'hC, 4, 1'b1);
      push_byte(8'h93, 1'b0);
      wait_strobes(base + 3);
      t0 = last_strobe_cyc;
      for (int i = 0; i < 100; i++) begin
         if (cyc >= t0 + 63) break;
         step();
      end
      chk("underrun_pre_slot", int'(underrun), 0);
      step();
      chk("underrun_set", int'(underrun), 1);
      wait_idle();
      chk("underrun_sticky", int'(underrun), 1);

      // Mode abort mid DATA_LO; the second frame sits in the FIFO and must be flushed
      base = strobe_cnt;
      expn(4'hC, 0);
      expn(4'h5, 64);
      push_byte(8'h5A, 1'b1);
      push_byte(8'h77, 1'b1);
      wait_strobes(base + 2);
      repeat (10) step();
      mode = 3'b000;
      step();
      chk("abort_busy", int'(busy), 0);
      chk("abort_ready", int'(byte_in_ready), 1);
      repeat (100) step();
      mode = 3'b101;
      repeat (300) step();
      chk("abort_strobes", strobe_cnt - base, 2);
      chk("abort_queue", exp_q.size(), 0);
      chk("abort_idle", int'(busy), 0);

      // Reset during END, then a clean frame
      base = strobe_cnt;
      expn(4'hC, 0);
      expn(4'h1, 64);
      expn(4'h1, 64);
      expn(4'h0, 64);
      push_byte(8'h11, 1'b1);
      wait_strobes(base + 4);
      repeat (5) step();
      reset = 1'b1;
      step();
      chk("mid_rst_nibble", int'(nibble_out), 0);
      chk("mid_rst_avail", int'(nibble_out_available), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_underrun", int'(underrun), 0);
      chk("mid_rst_ready", int'(byte_in_ready), 0);
      reset = 1'b0;
      step();
      chk("mid_rst_ready_rise", int'(byte_in_ready), 1);
      repeat (3) step();
      chk("mid_rst_no_strobe", strobe_cnt - base, 4);
      bq.push_back(8'h3C);
      add_frame(4'hC, 4, 1'b0);
      push_byte(8'h3C, 1'b1);
      chk_first_latency();
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
